// File: rtl/axi2apb_xfer_pkg.sv
// Shared types and constants for the AXI-to-APB transfer engine.
package axi2apb_xfer_pkg;

  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam int unsigned RESP_BITS = 2;

  localparam logic [STRB_BITS-1:0] STRB_FULL   = {STRB_BITS{1'b1}};
  localparam logic [RESP_BITS-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_BITS-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // PSEL is asserted for the whole SETUP/ACCESS span.
  function automatic logic apb_active(input state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/axi2apb_xfer_if.sv
// Command-queue, AXI W/B/R and APB3 signals of the transfer engine.
interface axi2apb_xfer_if #(
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 24
) ();

  logic                                         cmd_empty;
  logic                                         cmd_read;
  logic [ID_BITS-1:0]                           cmd_id;
  logic [ADDR_BITS-1:0]                         cmd_addr;
  logic                                         cmd_err;
  logic                                         finish_wr;
  logic                                         finish_rd;

  logic [axi2apb_xfer_pkg::DATA_BITS-1:0]       WDATA;
  logic [axi2apb_xfer_pkg::STRB_BITS-1:0]       WSTRB;
  logic                                         WLAST;
  logic                                         WVALID;
  logic                                         WREADY;

  logic [ID_BITS-1:0]                           BID;
  logic [axi2apb_xfer_pkg::RESP_BITS-1:0]       BRESP;
  logic                                         BVALID;
  logic                                         BREADY;

  logic [ID_BITS-1:0]                           RID;
  logic [axi2apb_xfer_pkg::DATA_BITS-1:0]       RDATA;
  logic [axi2apb_xfer_pkg::RESP_BITS-1:0]       RRESP;
  logic                                         RLAST;
  logic                                         RVALID;
  logic                                         RREADY;

  logic                                         PSEL;
  logic                                         PENABLE;
  logic                                         PWRITE;
  logic [ADDR_BITS-1:0]                         PADDR;
  logic [axi2apb_xfer_pkg::DATA_BITS-1:0]       PWDATA;
  logic [axi2apb_xfer_pkg::DATA_BITS-1:0]       PRDATA;
  logic                                         PREADY;
  logic                                         PSLVERR;

  // Transfer engine side.
  modport master (
    input  cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err,
    output finish_wr, finish_rd,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // Queue / AXI master / APB slave side.
  modport slave (
    output cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err,
    input  finish_wr, finish_rd,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/axi2apb_xfer.sv
// Pops one queued AXI command, runs a single APB3 transfer for it and
// returns the AXI B/R response; finish_* releases the queue entry.
module axi2apb_xfer
  import axi2apb_xfer_pkg::*;
#(
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 24
) (
  input  logic               clk,
  input  logic               resetn,
  axi2apb_xfer_if.master     bus
);

  state_e                  state_q,   state_d;
  logic                    read_q,    read_d;
  logic                    err_q,     err_d;
  logic [ID_BITS-1:0]      id_q,      id_d;
  logic [ADDR_BITS-1:0]    addr_q,    addr_d;
  logic [DATA_BITS-1:0]    wdata_q,   wdata_d;
  logic [DATA_BITS-1:0]    rdata_q,   rdata_d;
  logic [RESP_BITS-1:0]    resp_q,    resp_d;
  logic                    wready_q,  wready_d;
  logic                    psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic                    bvalid_q,  bvalid_d;
  logic                    rvalid_q,  rvalid_d;
  logic                    rlast_q,   rlast_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      read_q    <= 1'b0;
      err_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      wready_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      err_q     <= err_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      wready_q  <= wready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    err_d   = err_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.cmd_empty) begin
          read_d  = bus.cmd_read;
          err_d   = bus.cmd_err;
          id_d    = bus.cmd_id;
          addr_d  = bus.cmd_addr;
          resp_d  = RESP_OKAY;
          rdata_d = '0;
          if (!bus.cmd_read) begin
            state_d = ST_WDATA;
          end else if (bus.cmd_err) begin
            state_d = ST_RESP;
            resp_d  = RESP_SLVERR;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_WDATA: begin
        // Errored bursts are drained to WLAST; partial strobes cannot map onto APB3.
        if (bus.WVALID && wready_q) begin
          wdata_d = bus.WDATA;
          if (err_q) begin
            if (bus.WLAST) begin
              state_d = ST_RESP;
              resp_d  = RESP_SLVERR;
            end
          end else if (bus.WSTRB != STRB_FULL) begin
            state_d = ST_RESP;
            resp_d  = RESP_SLVERR;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d = ST_RESP;
          resp_d  = bus.PSLVERR ? RESP_SLVERR : RESP_OKAY;
          rdata_d = (read_q && !bus.PSLVERR) ? bus.PRDATA : '0;
        end
      end
      ST_RESP: begin
        if (read_q ? (rvalid_q && bus.RREADY) : (bvalid_q && bus.BREADY)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so they are valid in the same cycle as it.
    wready_d  = (state_d == ST_WDATA);
    psel_d    = apb_active(state_d);
    penable_d = (state_d == ST_ACCESS);
    pwrite_d  = apb_active(state_d) && !read_d;
    bvalid_d  = (state_d == ST_RESP) && !read_d;
    rvalid_d  = (state_d == ST_RESP) && read_d;
    rlast_d   = rvalid_d;
  end

  assign bus.finish_wr = bvalid_q & bus.BREADY;
  assign bus.finish_rd = rvalid_q & bus.RREADY;

  assign bus.WREADY  = wready_q;
  assign bus.BID     = id_q;
  assign bus.BRESP   = resp_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.RID     = id_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = resp_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = addr_q;
  assign bus.PWDATA  = wdata_q;

endmodule

// File: tb/tb_axi2apb_xfer.sv
// Scoreboard bench for axi2apb_xfer: a command queue model, an APB slave
// with programmable wait states and a negedge monitor that checks responses.
module tb_axi2apb_xfer;

  typedef struct packed {
    logic        rd;
    logic [3:0]  id;
    logic [23:0] addr;
    logic        err;
  } cmd_t;

  typedef struct packed {
    logic        rd;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        apb;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        lat;
    logic [3:0]  beats;
    logic [3:0]  acc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  axi2apb_xfer_if #(.ID_BITS(4), .ADDR_BITS(24)) bus ();

  axi2apb_xfer #(.ID_BITS(4), .ADDR_BITS(24)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Command queue model: stimulus appends, the pop process advances rd_ptr.
  cmd_t       cmd_mem [16];
  exp_t       exp_mem [16];
  logic [3:0] n_cmd  = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  cmd_t       head;

  assign head          = cmd_mem[rd_ptr];
  assign bus.cmd_empty = (rd_ptr == n_cmd);
  assign bus.cmd_read  = head.rd;
  assign bus.cmd_id    = head.id;
  assign bus.cmd_addr  = head.addr;
  assign bus.cmd_err   = head.err;

  always @(negedge clk) begin
    if (bus.finish_wr || bus.finish_rd) rd_ptr <= rd_ptr + 4'd1;
  end

  // APB slave: PREADY after ap_wait low ACCESS cycles; PSLVERR on one address.
  int          ap_wait     = 0;
  int          wcnt        = 0;
  logic [31:0] ap_rdata    = '0;
  logic        ap_err_en   = 1'b0;
  logic [23:0] ap_err_addr = '0;

  assign bus.PREADY  = bus.PSEL & bus.PENABLE & (wcnt >= ap_wait);
  assign bus.PRDATA  = ap_rdata;
  assign bus.PSLVERR = ap_err_en & (bus.PADDR == ap_err_addr);

  always @(posedge clk) begin
    if (!(bus.PSEL && bus.PENABLE)) wcnt <= 0;
    else if (!bus.PREADY)           wcnt <= wcnt + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          start = 0;
  logic [3:0]  exp_rd = 4'd0;
  logic        busy = 1'b0, psel_seen = 1'b0, pen_seen = 1'b0, val_seen = 1'b0, prev_setup = 1'b0;
  logic [3:0]  beats = 4'd0, acc = 4'd0;
  logic [63:0] apb_snap = '0, r_snap = '0;
  exp_t        e;
  logic        stim_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic clear_txn();
    busy = 1'b0; psel_seen = 1'b0; pen_seen = 1'b0; val_seen = 1'b0;
    prev_setup = 1'b0; beats = 4'd0; acc = 4'd0;
  endtask

  always @(negedge clk) begin
    cyc++;
    e = exp_mem[exp_rd];
    if (cyc > 20000) begin
      total++; bad++;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (stim_done) begin
      chk("all_responses", 64'(exp_rd), 64'(n_cmd));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (!resetn) begin
      chk("reset_ctrl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.BVALID, bus.RVALID,
                             bus.RLAST, bus.WREADY, bus.finish_wr, bus.finish_rd}), 64'd0);
      chk("reset_apb_data", 64'({bus.PADDR, bus.PWDATA}), 64'd0);
      chk("reset_resp", 64'({bus.RDATA, bus.RID, bus.BID, bus.RRESP, bus.BRESP}), 64'd0);
      clear_txn();
    end else if (busy) begin
      if (bus.WVALID && bus.WREADY) beats++;
      if (prev_setup) chk("setup_to_access", 64'({bus.PSEL, bus.PENABLE}), 64'd3);
      if (bus.PSEL && !bus.PENABLE && !psel_seen) begin
        psel_seen = 1'b1;
        chk("apb_expected", 64'(e.apb), 64'd1);
        if (e.lat) chk("psel_latency", 64'(cyc - start), 64'd1);
        chk("paddr", 64'(bus.PADDR), 64'(e.addr));
        chk("pwrite", 64'(bus.PWRITE), 64'(!e.rd));
        if (!e.rd) chk("pwdata", 64'(bus.PWDATA), 64'(e.wdata));
        apb_snap = 64'({bus.PADDR, bus.PWRITE, bus.PWDATA});
      end
      if (bus.PSEL && bus.PENABLE) begin
        acc++;
        if (!pen_seen) begin
          pen_seen = 1'b1;
          if (e.lat) chk("penable_latency", 64'(cyc - start), 64'd2);
        end
        chk("apb_stable", 64'({bus.PADDR, bus.PWRITE, bus.PWDATA}), apb_snap);
      end
      prev_setup = bus.PSEL && !bus.PENABLE;
      if (bus.RVALID || bus.BVALID) begin
        if (!val_seen) begin
          val_seen = 1'b1;
          r_snap = 64'({bus.RID, bus.RRESP, bus.RDATA, bus.BID, bus.BRESP});
          if (e.lat) chk("rvalid_latency", 64'(cyc - start), 64'd3);
        end else begin
          chk("resp_stable", 64'({bus.RID, bus.RRESP, bus.RDATA, bus.BID, bus.BRESP}), r_snap);
        end
        chk("finish_pulse", 64'({bus.finish_wr, bus.finish_rd}),
            64'({bus.BVALID & bus.BREADY, bus.RVALID & bus.RREADY}));
        if ((bus.RVALID && bus.RREADY) || (bus.BVALID && bus.BREADY)) begin
          chk("resp_expected", 64'(exp_rd != n_cmd), 64'd1);
          chk("resp_kind", 64'({bus.RVALID, bus.BVALID}), e.rd ? 64'd2 : 64'd1);
          if (e.rd) begin
            chk("rid", 64'(bus.RID), 64'(e.id));
            chk("rresp", 64'(bus.RRESP), 64'(e.resp));
            chk("rdata", 64'(bus.RDATA), 64'(e.data));
            chk("rlast", 64'(bus.RLAST), 64'd1);
          end else begin
            chk("bid", 64'(bus.BID), 64'(e.id));
            chk("bresp", 64'(bus.BRESP), 64'(e.resp));
          end
          chk("w_beats", 64'(beats), 64'(e.beats));
          chk("access_cycles", 64'(acc), 64'(e.acc));
          chk("apb_seen", 64'(psel_seen), 64'(e.apb));
          exp_rd = exp_rd + 4'd1;
          clear_txn();
        end
      end
    end else if (!bus.cmd_empty) begin
      clear_txn();
      busy  = 1'b1;
      start = cyc;
    end
  end

  // ---------------- stimulus ----------------
  function automatic exp_t mk(input logic rd, input logic [3:0] id, input logic [1:0] resp,
                              input logic [31:0] data, input logic apb, input logic [23:0] addr,
                              input logic [31:0] wdata, input logic lat, input logic [3:0] nb,
                              input logic [3:0] na);
    exp_t x;
    x.rd = rd; x.id = id; x.resp = resp; x.data = data; x.apb = apb; x.addr = addr;
    x.wdata = wdata; x.lat = lat; x.beats = nb; x.acc = na;
    return x;
  endfunction

  task automatic push(input logic rd, input logic [3:0] id, input logic [23:0] addr,
                      input logic err, input exp_t x);
    cmd_t c;
    c.rd = rd; c.id = id; c.addr = addr; c.err = err;
    cmd_mem[n_cmd] = c;
    exp_mem[n_cmd] = x;
    n_cmd = n_cmd + 4'd1;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bus.WDATA = d; bus.WSTRB = s; bus.WLAST = last; bus.WVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (bus.WREADY) break;
    end
    #1 bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (rd_ptr == n_cmd) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Plain read, zero wait states.
    ap_wait = 0; ap_rdata = 32'hDEADBEEF;
    push(1'b1, 4'd3, 24'h000104, 1'b0,
         mk(1'b1, 4'd3, 2'b00, 32'hDEADBEEF, 1'b1, 24'h000104, 32'h0, 1'b1, 4'd0, 4'd1));
    drain();

    // Full-strobe write with two wait states.
    ap_wait = 2;
    push(1'b0, 4'd1, 24'h000010, 1'b0,
         mk(1'b0, 4'd1, 2'b00, 32'h0, 1'b1, 24'h000010, 32'h12345678, 1'b0, 4'd1, 4'd3));
    w_beat(32'h12345678, 4'hF, 1'b1);
    drain();

    // Unsupported write burst: drain four beats, no APB access.
    push(1'b0, 4'd2, 24'h000030, 1'b1,
         mk(1'b0, 4'd2, 2'b10, 32'h0, 1'b0, 24'h000030, 32'h0, 1'b0, 4'd4, 4'd0));
    for (int i = 0; i < 4; i++) w_beat(32'h1000 + 32'(i), 4'hF, i == 3);
    drain();

    // Partial-strobe write is refused.
    push(1'b0, 4'd4, 24'h000040, 1'b0,
         mk(1'b0, 4'd4, 2'b10, 32'h0, 1'b0, 24'h000040, 32'h0, 1'b0, 4'd1, 4'd0));
    w_beat(32'hCAFEF00D, 4'h3, 1'b1);
    drain();

    // Slave error read with RREADY back-pressure, then a queued read.
    ap_wait = 0; ap_rdata = 32'h13579BDF; ap_err_en = 1'b1; ap_err_addr = 24'h000050;
    bus.RREADY = 1'b0;
    push(1'b1, 4'd6, 24'h000050, 1'b0,
         mk(1'b1, 4'd6, 2'b10, 32'h0, 1'b1, 24'h000050, 32'h0, 1'b1, 4'd0, 4'd1));
    push(1'b1, 4'd7, 24'h000060, 1'b0,
         mk(1'b1, 4'd7, 2'b00, 32'h13579BDF, 1'b1, 24'h000060, 32'h0, 1'b1, 4'd0, 4'd1));
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.RVALID) break;
    end
    repeat (4) @(posedge clk);
    #1 bus.RREADY = 1'b1;
    drain();
    ap_err_en = 1'b0;

    // Unsupported read answers SLVERR without touching APB.
    push(1'b1, 4'd9, 24'h000070, 1'b1,
         mk(1'b1, 4'd9, 2'b10, 32'h0, 1'b0, 24'h000070, 32'h0, 1'b0, 4'd0, 4'd0));
    drain();

    // Reset during ACCESS; the same head command is served afterwards.
    ap_wait = 3;
    push(1'b0, 4'd5, 24'h000020, 1'b0,
         mk(1'b0, 4'd5, 2'b00, 32'h0, 1'b1, 24'h000020, 32'hA5A55A5A, 1'b0, 4'd1, 4'd4));
    w_beat(32'hA5A55A5A, 4'hF, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.PENABLE) break;
    end
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    w_beat(32'hA5A55A5A, 4'hF, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

endmodule
